alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 183 ++++++++++++++++++
 tb/tb_alu_seq.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with an iterative shift-and-add multiplier.
//
// Ops 0-9 and the reserved codes finish on the accept edge. o_valid is high
// for one cycle after that edge. MUL/MULH (ops 10/11, when MUL_EN=1) run for
// WIDTH cycles in the MUL state. The result and flags are then registered,
// and the block returns to IDLE.
//
// Handshake: a request is taken on a rising edge where i_valid && o_ready.
// o_ready is high only in IDLE. While busy in MUL, requests are dropped and
// never queued. o_valid is a single-cycle pulse with no back-pressure.
//
// Ports:
//   i_clk, i_reset_n     clock, asynchronous active-low reset
//   i_valid / o_ready    request handshake
//   i_op                 operation code (0 ADD .. 11 MULH, 12-15 reserved)
//   i_alu_l, i_alu_r     operands
//   o_valid              one-cycle pulse when o_alu/o_flags are new
//   o_alu                registered result
//   o_flags              registered flags {V,N,C,Z}
//   o_dbg_state          FSM state (0 = IDLE, 1 = MUL) for observation
module alu_seq #(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_alu_l,
  input  logic [WIDTH-1:0] i_alu_r,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_alu,
  output logic [3:0]       o_flags,
  output logic             o_dbg_state
);

  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_is_mulh;
  logic [2*WIDTH-1:0] r_prod;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic               r_valid;
  logic [WIDTH-1:0]   r_alu;
  logic [3:0]         r_flags;

  logic               w_mul_op;
  logic [WIDTH-1:0]   w_rhs;
  logic               w_cin;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_alu_res;
  logic [3:0]         w_alu_flags;
  logic               w_c;
  logic               w_v;
  logic               w_reserved;
  logic [2*WIDTH-1:0] w_prod_nxt;
  logic [WIDTH-1:0]   w_mul_res;
  logic [3:0]         w_mul_flags;

  assign w_mul_op = (MUL_EN != 0) && ((i_op == 4'd10) || (i_op == 4'd11));

  // Subtraction is l + ~r + carry-in. A carry out of the top bit then means
  // "no borrow". For SBC, the carry-in is the stored C: l - r - ~C == l + ~r + C.
  always_comb begin
    w_rhs = i_alu_r;
    w_cin = 1'b0;
    case (i_op)
      4'd1:    w_cin = r_flags[1];
      4'd2:    begin w_rhs = ~i_alu_r; w_cin = 1'b1;       end
      4'd3:    begin w_rhs = ~i_alu_r; w_cin = r_flags[1]; end
      default: ;
    endcase
    w_sum = {1'b0, i_alu_l} + {1'b0, w_rhs} + {{WIDTH{1'b0}}, w_cin};
  end

  always_comb begin
    w_alu_res  = i_alu_l;
    w_c        = r_flags[1];
    w_v        = 1'b0;
    w_reserved = 1'b0;
    case (i_op)
      4'd0, 4'd1, 4'd2, 4'd3: begin
        w_alu_res = w_sum[WIDTH-1:0];
        w_c       = w_sum[WIDTH];
        // Overflow when both addends share a sign that the sum does not.
        w_v       = (i_alu_l[WIDTH-1] == w_rhs[WIDTH-1]) &&
                    (w_sum[WIDTH-1] != i_alu_l[WIDTH-1]);
      end
      4'd4: w_alu_res = i_alu_l & i_alu_r;
      4'd5: w_alu_res = i_alu_l | i_alu_r;
      4'd6: w_alu_res = i_alu_l ^ i_alu_r;
      4'd7: begin
        w_alu_res = {i_alu_l[WIDTH-2:0], 1'b0};
        w_c       = i_alu_l[WIDTH-1];
      end
      4'd8: begin
        w_alu_res = {1'b0, i_alu_l[WIDTH-1:1]};
        w_c       = i_alu_l[0];
      end
      4'd9: begin
        w_alu_res = {i_alu_l[WIDTH-1], i_alu_l[WIDTH-1:1]};
        w_c       = i_alu_l[0];
      end
      // Ops 10/11 reach here only with MUL_EN=0, so they act as reserved.
      default: w_reserved = 1'b1;
    endcase
    if (w_reserved) w_alu_flags = r_flags;
    else            w_alu_flags = {w_v, w_alu_res[WIDTH-1], w_c, (w_alu_res == '0)};
  end

  // One shift-and-add step. On the last step, this value is the full product.
  always_comb begin
    w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);
    if (r_is_mulh) begin
      w_mul_res   = w_prod_nxt[2*WIDTH-1:WIDTH];
      w_mul_flags = {1'b0, w_mul_res[WIDTH-1], 1'b0, (w_mul_res == '0)};
    end else begin
      w_mul_res   = w_prod_nxt[WIDTH-1:0];
      w_mul_flags = {1'b0, w_mul_res[WIDTH-1], (w_prod_nxt[2*WIDTH-1:WIDTH] != '0),
                     (w_mul_res == '0)};
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_is_mulh <= 1'b0;
      r_prod    <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_valid   <= 1'b0;
      r_alu     <= '0;
      r_flags   <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_valid) begin
            if (w_mul_op) begin
              r_state   <= MUL;
              r_cnt     <= '0;
              r_is_mulh <= i_op[0];
              r_prod    <= '0;
              r_mcand   <= {{WIDTH{1'b0}}, i_alu_l};
              r_mplier  <= i_alu_r;
            end else begin
              r_alu   <= w_alu_res;
              r_flags <= w_alu_flags;
              r_valid <= 1'b1;
            end
          end
        end
        MUL: begin
          r_prod   <= w_prod_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= IDLE;
            r_alu   <= w_mul_res;
            r_flags <= w_mul_flags;
            r_valid <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_ready     = (r_state == IDLE);
  assign o_valid     = r_valid;
  assign o_alu       = r_alu;
  assign o_flags     = r_flags;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8). Inputs change 1 time unit after a
// rising edge, and outputs are sampled at the same offset.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         valid_in;
  logic         ready;
  logic [3:0]   op;
  logic [W-1:0] l;
  logic [W-1:0] r;
  logic         valid_out;
  logic [W-1:0] alu;
  logic [3:0]   flags;
  logic         dbg_state;

  int n_pass;
  int n_total;
  int pulses;

  alu_seq #(.WIDTH(W), .MUL_EN(1)) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_valid     (valid_in),
    .o_ready     (ready),
    .i_op        (op),
    .i_alu_l     (l),
    .i_alu_r     (r),
    .o_valid     (valid_out),
    .o_alu       (alu),
    .o_flags     (flags),
    .o_dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
  endtask

  task automatic drive(input logic v, input logic [3:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    valid_in = v;
    op       = o;
    l        = a;
    r        = b;
  endtask

  // Check a completed result: pulse, value and flags {V,N,C,Z}.
  task automatic chk_res(input string tag, input logic [W-1:0] exp_alu,
                         input logic [3:0] exp_flags);
    chk({tag, "_valid"}, 32'(valid_out), 32'd1);
    chk({tag, "_alu"},   32'(alu),       32'(exp_alu));
    chk({tag, "_flags"}, 32'(flags),     32'(exp_flags));
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    drive(1'b0, 4'd0, 8'h00, 8'h00);
    repeat (2) cyc();
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_alu",   32'(alu),       32'd0);
    chk("rst_flags", 32'(flags),     32'd0);
    chk("rst_ready", 32'(ready),     32'd1);
    rst_n = 1'b1;
    cyc();

    // ADD 0xFF+0x01, then ADC using its carry, then two SUBs, back to back.
    drive(1'b1, 4'd0, 8'hFF, 8'h01); cyc();
    chk_res("add", 8'h00, 4'b0011);
    drive(1'b1, 4'd1, 8'h10, 8'h20); cyc();
    chk_res("adc", 8'h31, 4'b0000);
    drive(1'b1, 4'd2, 8'h05, 8'h06); cyc();
    chk_res("sub1", 8'hFF, 4'b0100);
    drive(1'b1, 4'd2, 8'h80, 8'h01); cyc();
    chk_res("sub2", 8'h7F, 4'b1010);

    // MUL 0x12*0x34 = 0x03A8. A conflicting ADD is held on i_valid while busy.
    drive(1'b1, 4'd10, 8'h12, 8'h34); cyc();
    drive(1'b1, 4'd0, 8'hFF, 8'h01);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("mul_busy_ready_c%0d", i), 32'(ready),     32'd0);
      chk($sformatf("mul_busy_valid_c%0d", i), 32'(valid_out), 32'd0);
      cyc();
    end
    chk_res("mul", 8'hA8, 4'b0110);
    chk("mul_ready_after", 32'(ready), 32'd1);

    // MULH with the same operands, issued in the completion cycle.
    drive(1'b1, 4'd11, 8'h12, 8'h34); cyc();
    drive(1'b0, 4'd0, 8'h00, 8'h00);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("mulh_busy_valid_c%0d", i), 32'(valid_out), 32'd0);
      cyc();
    end
    chk_res("mulh", 8'h03, 4'b0000);
    cyc();
    chk("mulh_pulse_one_cycle", 32'(valid_out), 32'd0);
    chk("hold_alu", 32'(alu), 32'h03);

    // Reset 4 cycles into a MUL: no completion, cleared outputs, ready after.
    drive(1'b1, 4'd10, 8'h12, 8'h34); cyc();
    drive(1'b0, 4'd0, 8'h00, 8'h00);
    repeat (3) cyc();
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(valid_out), 32'd0);
    chk("abort_alu",   32'(alu),       32'd0);
    chk("abort_flags", 32'(flags),     32'd0);
    chk("abort_ready", 32'(ready),     32'd1);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("abort_ready_release", 32'(ready), 32'd1);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (valid_out) pulses++;
      cyc();
    end
    chk("abort_no_pulse", 32'(pulses), 32'd0);

    // Logic ops and SHR issued on consecutive cycles, then a reserved code.
    drive(1'b1, 4'd4, 8'hF0, 8'h3C); cyc();
    chk_res("and", 8'h30, 4'b0000);
    drive(1'b1, 4'd5, 8'h80, 8'h01); cyc();
    chk_res("or", 8'h81, 4'b0100);
    drive(1'b1, 4'd6, 8'h5A, 8'h5A); cyc();
    chk_res("xor", 8'h00, 4'b0001);
    drive(1'b1, 4'd8, 8'h01, 8'h00); cyc();
    chk_res("shr", 8'h00, 4'b0011);
    drive(1'b1, 4'd14, 8'hC3, 8'h55); cyc();
    chk_res("reserved", 8'hC3, 4'b0011);

    // Remaining shifts and SBC using the carry from SHL.
    drive(1'b1, 4'd9, 8'h81, 8'h00); cyc();
    chk_res("asr", 8'hC0, 4'b0110);
    drive(1'b1, 4'd7, 8'h81, 8'h00); cyc();
    chk_res("shl", 8'h02, 4'b0010);
    drive(1'b1, 4'd3, 8'h10, 8'h01); cyc();
    chk_res("sbc", 8'h0F, 4'b0010);
    drive(1'b0, 4'd0, 8'h00, 8'h00); cyc();
    chk("idle_valid", 32'(valid_out), 32'd0);
    chk("idle_hold_alu", 32'(alu), 32'h0F);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
